// File: rtl/network_sample_sequencer_pkg.sv
// Shared definitions for the network sample sequencer: sequencer states
// and the index-width helper used to size counters.
package network_sample_sequencer_pkg;

    // Sequencer states; encodings are fixed so they match the network driver headers.
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        DRAIN   = 2'd3
    } seq_state_t;

    // Bits needed to index 'value' entries; never narrower than one bit.
    function automatic int log2(input int value);
        int width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/network_sample_sequencer_layer_vec_serializer.sv
// Captures a full hidden-state vector in one edge and streams it out one
// neuron word per valid/ready handshake, neuron 0 first.
module network_sample_sequencer_layer_vec_serializer
    import network_sample_sequencer_pkg::*;
#(
    parameter int HIDDEN_SZ = 8,
    parameter int BITWIDTH  = 18
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          load,
    input  logic [BITWIDTH*HIDDEN_SZ-1:0] vec,
    output logic [BITWIDTH-1:0]           outWord,
    output logic                          outValid,
    input  logic                          outReady,
    output logic                          outLast,
    output logic                          done
);

    localparam int OIDX_W = log2(HIDDEN_SZ);
    localparam logic [OIDX_W-1:0] OIDX_LAST = OIDX_W'(HIDDEN_SZ - 1);

    logic [HIDDEN_SZ-1:0][BITWIDTH-1:0] shadow;
    logic [OIDX_W-1:0]                  oIdx;
    logic                               is_last;

    assign is_last = (oIdx == OIDX_LAST);
    assign outWord = shadow[oIdx];
    assign outLast = outValid && is_last;
    assign done    = outValid && outReady && is_last;

    // Shadow capture on load, then advance one neuron per accepted word.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow   <= '0;
            oIdx     <= '0;
            outValid <= 1'b0;
        end else if (load) begin
            shadow   <= vec;
            oIdx     <= '0;
            outValid <= 1'b1;
        end else if (outValid && outReady) begin
            if (is_last) begin
                oIdx     <= '0;
                outValid <= 1'b0;
            end else begin
                oIdx <= oIdx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/network_sample_sequencer.sv
// Drives the LSTM network block: packs input words into the network input
// vector, launches a sample, waits for dataReady, then streams the hidden
// state back out through the serializer.
module network_sample_sequencer
    import network_sample_sequencer_pkg::*;
#(
    parameter int INPUT_SZ       = 2,
    parameter int HIDDEN_SZ      = 8,
    parameter int QN             = 6,
    parameter int QM             = 11,
    parameter int BITWIDTH       = QN + QM + 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [BITWIDTH-1:0]           inWord,
    input  logic                          inValid,
    output logic                          inReady,
    output logic [BITWIDTH*INPUT_SZ-1:0]  netInputVec,
    output logic                          netNewSample,
    input  logic                          netDataReady,
    input  logic [BITWIDTH*HIDDEN_SZ-1:0] netOutputVec,
    output logic [BITWIDTH-1:0]           outWord,
    output logic                          outValid,
    input  logic                          outReady,
    output logic                          outLast,
    output logic                          busy,
    output logic                          timeoutErr,
    input  logic                          clearErr,
    output logic [15:0]                   samplesDone
);

    localparam int WIDX_W = log2(INPUT_SZ);
    localparam int TMR_W  = log2(TIMEOUT_CYCLES);
    localparam logic [WIDX_W-1:0] WIDX_LAST  = WIDX_W'(INPUT_SZ - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam bit                TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    seq_state_t                        state;
    logic [INPUT_SZ-1:0][BITWIDTH-1:0] in_vec;
    logic [WIDX_W-1:0]                 wIdx;
    logic [TMR_W-1:0]                  timer;
    logic                              rdy_q;
    logic                              rise;
    logic                              accept;
    logic                              load;
    logic                              done;

    assign inReady     = (state == COLLECT) && !reset;
    assign accept      = inValid && inReady;
    assign rise        = netDataReady && !rdy_q;
    assign load        = (state == WAIT) && rise;
    assign netInputVec = in_vec;
    assign busy        = (state != COLLECT) || (wIdx != '0);

    // dataReady history for rising-edge detection, independent of state and reset.
    always_ff @(posedge clock) begin
        rdy_q <= netDataReady;
    end

    // Sequencer FSM: input packing, launch pulse, bounded wait, drain bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= COLLECT;
            in_vec       <= '0;
            wIdx         <= '0;
            timer        <= '0;
            netNewSample <= 1'b0;
            timeoutErr   <= 1'b0;
            samplesDone  <= '0;
        end else begin
            netNewSample <= 1'b0;
            // A timeout set later in this block overrides the clear.
            if (clearErr) timeoutErr <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        in_vec[wIdx] <= inWord;
                        if (wIdx == WIDX_LAST) begin
                            wIdx         <= '0;
                            netNewSample <= 1'b1;
                            state        <= LAUNCH;
                        end else begin
                            wIdx <= wIdx + 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (rise) begin
                        state <= DRAIN;
                    end else if (TIMEOUT_EN && (timer == TMR_LAST)) begin
                        timeoutErr <= 1'b1;
                        state      <= COLLECT;
                    end
                end
                DRAIN: begin
                    if (done) begin
                        samplesDone <= samplesDone + 16'd1;
                        state       <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    network_sample_sequencer_layer_vec_serializer #(
        .HIDDEN_SZ (HIDDEN_SZ),
        .BITWIDTH  (BITWIDTH)
    ) u_serializer (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .vec      (netOutputVec),
        .outWord  (outWord),
        .outValid (outValid),
        .outReady (outReady),
        .outLast  (outLast),
        .done     (done)
    );

endmodule

// File: tb/tb_network_sample_sequencer.sv
// Scoreboard bench for network_sample_sequencer with a behavioural network model.
module tb_network_sample_sequencer;

    localparam int INPUT_SZ       = 2;
    localparam int HIDDEN_SZ      = 8;
    localparam int BITWIDTH       = 18;
    localparam int TIMEOUT_CYCLES = 16;

    logic                          clock = 1'b0;
    logic                          reset;
    logic [BITWIDTH-1:0]           inWord;
    logic                          inValid;
    logic                          inReady;
    logic [BITWIDTH*INPUT_SZ-1:0]  netInputVec;
    logic                          netNewSample;
    logic                          netDataReady;
    logic [BITWIDTH*HIDDEN_SZ-1:0] netOutputVec;
    logic [BITWIDTH-1:0]           outWord;
    logic                          outValid;
    logic                          outReady;
    logic                          outLast;
    logic                          busy;
    logic                          timeoutErr;
    logic                          clearErr;
    logic [15:0]                   samplesDone;

    always #5 clock = ~clock;

    network_sample_sequencer #(
        .INPUT_SZ       (INPUT_SZ),
        .HIDDEN_SZ      (HIDDEN_SZ),
        .QN             (6),
        .QM             (11),
        .BITWIDTH       (BITWIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .inWord       (inWord),
        .inValid      (inValid),
        .inReady      (inReady),
        .netInputVec  (netInputVec),
        .netNewSample (netNewSample),
        .netDataReady (netDataReady),
        .netOutputVec (netOutputVec),
        .outWord      (outWord),
        .outValid     (outValid),
        .outReady     (outReady),
        .outLast      (outLast),
        .busy         (busy),
        .timeoutErr   (timeoutErr),
        .clearErr     (clearErr),
        .samplesDone  (samplesDone)
    );

    int tests = 0;
    int fails = 0;
    int exp_done = 0;
    int hs_count = 0;
    int or_mode = 0;
    int pat_idx = 0;
    bit pat [6] = '{1, 0, 0, 1, 0, 1};
    logic [BITWIDTH:0]   exp_q [$];
    logic [BITWIDTH:0]   mon_e;
    logic                held_valid = 1'b0;
    logic [BITWIDTH-1:0] held_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // outReady generator: always ready, fixed stall pattern, or random.
    initial begin
        outReady = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (or_mode)
                0: outReady = 1'b1;
                1: begin
                    outReady = pat[pat_idx % 6];
                    pat_idx++;
                end
                default: outReady = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops expected words on every handshake and checks stall stability.
    always @(negedge clock) begin
        if (!reset && outValid) begin
            if (held_valid) check("hold_stable", outWord, held_word);
            if (outReady) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got word %0h, required no output", outWord);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_word", outWord, mon_e[BITWIDTH-1:0]);
                    check("out_last", outLast, mon_e[BITWIDTH]);
                end
                held_valid = 1'b0;
            end else begin
                held_valid = 1'b1;
                held_word  = outWord;
            end
        end else begin
            held_valid = 1'b0;
        end
    end

    task automatic send_word(input logic [BITWIDTH-1:0] w);
        int n = 0;
        repeat ($urandom_range(0, 2)) tick();
        inWord  = w;
        inValid = 1'b1;
        while (!inReady && n < 50) begin
            tick();
            n++;
        end
        if (!inReady) check("in_ready_timeout", inReady, 1);
        tick();
        inValid = 1'b0;
        inWord  = $urandom();
    endtask

    // Pack two words; returns in the first wait cycle after the launch pulse.
    task automatic send_sample(input logic [BITWIDTH-1:0] w0, input logic [BITWIDTH-1:0] w1);
        send_word(w0);
        check("busy_mid_pack", busy, 1);
        check("no_launch_mid_pack", netNewSample, 0);
        send_word(w1);
        check("launch_pulse", netNewSample, 1);
        check("input_vec", netInputVec, {w1, w0});
        tick();
        check("launch_once", netNewSample, 0);
        check("in_ready_wait", inReady, 0);
    endtask

    // Network model: after 'delay' cycles present a result vector and raise dataReady.
    task automatic respond(input int delay, input bit keep_high, input bit count_up);
        logic [BITWIDTH*HIDDEN_SZ-1:0] v;
        logic [BITWIDTH-1:0] w;
        repeat (delay) tick();
        for (int j = 0; j < HIDDEN_SZ; j++) begin
            w = count_up ? BITWIDTH'(j + 1) : BITWIDTH'($urandom());
            v[j*BITWIDTH +: BITWIDTH] = w;
            exp_q.push_back({(j == HIDDEN_SZ - 1), w});
        end
        netOutputVec = v;
        netDataReady = 1'b1;
        exp_done++;
        tick();
        if (!keep_high) netDataReady = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        bit ir_bad = 0;
        while (samplesDone != 16'(exp_done) && n < 400) begin
            if (outValid && inReady) ir_bad = 1;
            tick();
            n++;
        end
        check("samples_done", samplesDone, 16'(exp_done));
        check("busy_idle", busy, 0);
        check("queue_empty", exp_q.size(), 0);
        check("in_ready_during_drain", ir_bad, 0);
    endtask

    // Launch a sample that never gets dataReady; returns cycles until inReady returns.
    task automatic timeout_sample(input bit clear_coincident, output int k);
        send_sample($urandom(), $urandom());
        k = 1;
        while (!inReady && k < 40) begin
            if (clear_coincident && k == 16) clearErr = 1'b1;
            tick();
            clearErr = 1'b0;
            k++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int k;
        int base;
        reset        = 1'b1;
        inWord       = '0;
        inValid      = 1'b0;
        netDataReady = 1'b0;
        netOutputVec = '0;
        clearErr     = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", inReady, 0);
        check("rst_input_vec", netInputVec, 0);
        check("rst_new_sample", netNewSample, 0);
        check("rst_out_valid", outValid, 0);
        check("rst_out_last", outLast, 0);
        check("rst_out_word", outWord, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeoutErr, 0);
        check("rst_samples", samplesDone, 0);
        reset = 1'b0;
        tick();
        check("idle_in_ready", inReady, 1);

        // Directed pack and normal result with neuron j = j+1
        send_sample(18'h00100, 18'h3FF00);
        respond(12, 0, 1);
        wait_done();

        // Backpressure pattern
        or_mode = 1;
        send_sample($urandom(), $urandom());
        respond(5, 0, 0);
        wait_done();

        // Random samples with random stalls and delays
        or_mode = 2;
        for (int i = 0; i < 6; i++) begin
            send_sample($urandom(), $urandom());
            respond($urandom_range(0, 14), 0, 0);
            wait_done();
        end

        // Level dataReady carried over from a previous sample
        or_mode = 0;
        send_sample($urandom(), $urandom());
        respond(4, 1, 0);
        wait_done();
        send_sample($urandom(), $urandom());
        netOutputVec = {HIDDEN_SZ{18'h2AAAA}};
        repeat (6) tick();
        check("no_capture_on_level", outValid, 0);
        check("busy_waiting", busy, 1);
        netDataReady = 1'b0;
        tick();
        respond(2, 0, 0);
        wait_done();

        // Timeouts: set, clear, set again, then clear coincident with a new timeout
        timeout_sample(0, k);
        check("timeout_latency", k, 17);
        check("timeout_set", timeoutErr, 1);
        check("timeout_no_count", samplesDone, 16'(exp_done));
        check("timeout_no_valid", outValid, 0);
        clearErr = 1'b1;
        tick();
        clearErr = 1'b0;
        check("timeout_cleared", timeoutErr, 0);
        timeout_sample(0, k);
        check("timeout_latency2", k, 17);
        check("timeout_set2", timeoutErr, 1);
        timeout_sample(1, k);
        check("timeout_latency3", k, 17);
        check("timeout_set_wins", timeoutErr, 1);
        check("timeout_no_count3", samplesDone, 16'(exp_done));
        clearErr = 1'b1;
        tick();
        clearErr = 1'b0;
        check("timeout_cleared2", timeoutErr, 0);

        // Reset in the middle of a drain
        send_sample($urandom(), $urandom());
        respond(3, 0, 0);
        base = hs_count;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (hs_count >= base + 3) break;
        end
        check("handshakes_before_reset", hs_count - base, 3);
        reset = 1'b1;
        exp_q.delete();
        exp_done = 0;
        tick();
        check("mid_rst_out_valid", outValid, 0);
        check("mid_rst_input_vec", netInputVec, 0);
        check("mid_rst_samples", samplesDone, 0);
        check("mid_rst_in_ready", inReady, 0);
        reset = 1'b0;
        tick();
        send_sample($urandom(), $urandom());
        respond(7, 0, 0);
        wait_done();

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
